// File: rtl/hazard_unit.sv
// hazard_unit: hazard and forwarding controller that sits beside decode.
// Tracks {valid, dst, isload} for every in-flight instruction past decode,
// derives forwarding selects, load-use stalls, branch flushes and a
// whole-pipe freeze while data memory is busy.
// Optional: define HAZARD_STATS_EN to add StallCount/FlushCount outputs.

// Per-entry source match: one instance per tracked stage.
module hazard_entry_match #(
   parameter int W = 5
) (
   input  logic         vld,
   input  logic [W-1:0] dst,
   input  logic [W-1:0] src_a,
   input  logic [W-1:0] src_b,
   input  logic         use_a,
   input  logic         use_b,
   output logic         hit_a,
   output logic         hit_b
);
   // $0 is hardwired, so it never creates a dependency.
   assign hit_a = vld && (dst == src_a) && (dst != '0) && use_a;
   assign hit_b = vld && (dst == src_b) && (dst != '0) && use_b;
endmodule

module hazard_unit #(
   parameter int REG_ADDR_W = 5,
   parameter int STAGES     = 3,
   parameter int LOAD_LAT   = 1,
   parameter int BR_STAGE   = 2
) (
   input  logic                  CLOCK,
   input  logic                  RESET,
   input  logic                  IssueValid_D,
   input  logic [REG_ADDR_W-1:0] Rs_D,
   input  logic [REG_ADDR_W-1:0] Rt_D,
   input  logic                  UsesRs_D,
   input  logic                  UsesRt_D,
   input  logic [REG_ADDR_W-1:0] Dst_D,
   input  logic                  RegWriteEN_D,
   input  logic                  IsLoad_D,
   input  logic                  BranchTaken,
   input  logic                  MemBusy,
   output logic                  StallF,
   output logic                  StallD,
   output logic                  FlushD,
   output logic                  FlushE,
   output logic [2:0]            FwdA,
   output logic [2:0]            FwdB
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]           StallCount,
   output logic [31:0]           FlushCount
`endif
);

   // Entry k describes the instruction currently in stage k.
   logic [STAGES:1]                 vld_pipe;
   logic [STAGES:1]                 ld_pipe;
   logic [STAGES:1][REG_ADDR_W-1:0] dst_pipe;

   logic [STAGES:1] hit_a, hit_b;
   logic            lu_a, lu_b;
   logic            loaduse;
   logic            br_acc;

   for (genvar k = 1; k <= STAGES; k++) begin : g_ent
      hazard_entry_match #(.W(REG_ADDR_W)) u_match (
         .vld   (vld_pipe[k]),
         .dst   (dst_pipe[k]),
         .src_a (Rs_D),
         .src_b (Rt_D),
         .use_a (UsesRs_D),
         .use_b (UsesRt_D),
         .hit_a (hit_a[k]),
         .hit_b (hit_b[k])
      );
   end

   // Youngest match wins: scan oldest to youngest so the smallest k overrides.
   always_comb begin
      FwdA = '0;
      FwdB = '0;
      lu_a = 1'b0;
      lu_b = 1'b0;
      for (int k = STAGES; k >= 1; k--) begin
         if (hit_a[k]) begin
            FwdA = 3'(k);
            lu_a = ld_pipe[k] && (k <= LOAD_LAT);
         end
         if (hit_b[k]) begin
            FwdB = 3'(k);
            lu_b = ld_pipe[k] && (k <= LOAD_LAT);
         end
      end
   end

   assign loaduse = IssueValid_D && (lu_a || lu_b);
   // A branch is only acted on while memory is ready; the source holds it.
   assign br_acc  = BranchTaken && !MemBusy;

   // Control priority: memory freeze, then branch flush, then load-use stall.
   always_comb begin
      StallF = MemBusy || (loaduse && !BranchTaken);
      StallD = MemBusy || (loaduse && !BranchTaken);
      FlushD = br_acc;
      FlushE = br_acc || (loaduse && !MemBusy);
   end

   // Tag pipeline: shift when memory is ready, squash younger-than-branch entries.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         vld_pipe <= '0;
         ld_pipe  <= '0;
         dst_pipe <= '0;
      end else if (!MemBusy) begin
         vld_pipe[1] <= IssueValid_D && RegWriteEN_D && !loaduse && !BranchTaken;
         dst_pipe[1] <= Dst_D;
         ld_pipe[1]  <= IsLoad_D;
         for (int k = 1; k < STAGES; k++) begin
            vld_pipe[k+1] <= vld_pipe[k] && !(BranchTaken && (k < BR_STAGE));
            dst_pipe[k+1] <= dst_pipe[k];
            ld_pipe[k+1]  <= ld_pipe[k];
         end
      end
   end

`ifdef HAZARD_STATS_EN
   // Event counters; wrap naturally at 2^32.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         StallCount <= '0;
         FlushCount <= '0;
      end else begin
         if (loaduse || MemBusy) StallCount <= StallCount + 32'd1;
         if (br_acc)             FlushCount <= FlushCount + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: stimulus pushes expected outputs per
// cycle, a monitor pops and compares mid-cycle.
module tb_hazard_unit;

   typedef struct packed {
      logic       sf, sd, fd, fe;
      logic [2:0] fa, fb;
   } exp_t;

   logic       CLOCK = 1'b0;
   logic       RESET;
   logic       IssueValid_D;
   logic [4:0] Rs_D, Rt_D, Dst_D;
   logic       UsesRs_D, UsesRt_D, RegWriteEN_D, IsLoad_D;
   logic       BranchTaken, MemBusy;
   logic       StallF, StallD, FlushD, FlushE;
   logic [2:0] FwdA, FwdB;
`ifdef HAZARD_STATS_EN
   logic [31:0] StallCount, FlushCount;
`endif

   exp_t exp_q[$];
   int   id_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   hazard_unit dut (
      .CLOCK(CLOCK), .RESET(RESET), .IssueValid_D(IssueValid_D),
      .Rs_D(Rs_D), .Rt_D(Rt_D), .UsesRs_D(UsesRs_D), .UsesRt_D(UsesRt_D),
      .Dst_D(Dst_D), .RegWriteEN_D(RegWriteEN_D), .IsLoad_D(IsLoad_D),
      .BranchTaken(BranchTaken), .MemBusy(MemBusy),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .FwdA(FwdA), .FwdB(FwdB)
`ifdef HAZARD_STATS_EN
      , .StallCount(StallCount), .FlushCount(FlushCount)
`endif
   );

   always #5 CLOCK = ~CLOCK;

   function automatic exp_t mk(input logic sf, sd, fd, fe, input logic [2:0] fa, fb);
      exp_t e;
      e.sf = sf; e.sd = sd; e.fd = fd; e.fe = fe; e.fa = fa; e.fb = fb;
      return e;
   endfunction

   // Drive one decode cycle shortly after the edge and queue its expected outputs.
   task automatic step(input int id, input logic rst, iv,
                       input logic [4:0] rs, rt, input logic urs, urt,
                       input logic [4:0] dst, input logic rw, ld, br, mb,
                       input exp_t e);
      @(posedge CLOCK);
      #1;
      RESET = rst; IssueValid_D = iv; Rs_D = rs; Rt_D = rt;
      UsesRs_D = urs; UsesRt_D = urt; Dst_D = dst; RegWriteEN_D = rw;
      IsLoad_D = ld; BranchTaken = br; MemBusy = mb;
      exp_q.push_back(e);
      id_q.push_back(id);
   endtask

   // Monitor: outputs are presented every cycle; compare at the falling edge.
   initial begin
      exp_t e, got;
      int   id;
      forever begin
         @(negedge CLOCK);
         if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            got = mk(StallF, StallD, FlushD, FlushE, FwdA, FwdB);
            n_cmp++;
            if (got !== e) begin
               n_bad++;
               $display("FAIL vec%0d got sf%b sd%b fd%b fe%b fa%0d fb%0d required sf%b sd%b fd%b fe%b fa%0d fb%0d",
                        id, got.sf, got.sd, got.fd, got.fe, got.fa, got.fb,
                        e.sf, e.sd, e.fd, e.fe, e.fa, e.fb);
            end
         end
      end
   end

   initial begin
      exp_t z;
      z = mk(0, 0, 0, 0, 0, 0);
      RESET = 1'b1; IssueValid_D = 0; Rs_D = 0; Rt_D = 0; UsesRs_D = 0; UsesRt_D = 0;
      Dst_D = 0; RegWriteEN_D = 0; IsLoad_D = 0; BranchTaken = 0; MemBusy = 0;
      repeat (2) @(posedge CLOCK);
      //   id rst iv  rs  rt urs urt dst rw ld br mb  expected
      step( 0, 1, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, z);                   // reset state
      // ALU chain
      step( 1, 0, 1,  9, 10, 1, 1,  8, 1, 0, 0, 0, z);                   // add $8
      step( 2, 0, 1,  8,  8, 1, 1,  9, 1, 0, 0, 0, mk(0,0,0,0,1,1));     // add $9,$8,$8
      step( 3, 0, 1,  8,  0, 1, 1, 10, 1, 0, 0, 0, mk(0,0,0,0,2,0));     // $8 one slot later
      step( 4, 0, 1,  8,  9, 1, 1,  0, 0, 0, 0, 0, mk(0,0,0,0,3,2));     // oldest forward
      step( 5, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, z);
      step( 6, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, z);
      // register zero
      step( 7, 0, 1,  0,  0, 0, 0,  0, 1, 0, 0, 0, z);                   // write $0
      step( 8, 0, 1,  0,  0, 1, 1, 11, 1, 0, 0, 0, z);                   // read $0
      // load-use
      step( 9, 0, 1, 29,  0, 1, 0,  8, 1, 1, 0, 0, z);                   // lw $8
      step(10, 0, 1,  8,  0, 1, 1,  9, 1, 0, 0, 0, mk(1,1,0,1,1,0));     // stall
      step(11, 0, 1,  8,  0, 1, 1,  9, 1, 0, 0, 0, mk(0,0,0,0,2,0));     // forward from MEM
      // branch flush coincident with loaduse
      step(12, 0, 1,  0,  0, 0, 0, 12, 1, 1, 0, 0, z);                   // lw $12
      step(13, 0, 1, 12,  0, 1, 0, 13, 1, 0, 1, 0, mk(0,0,1,1,1,0));     // flush wins
      step(14, 0, 1, 12,  9, 1, 1,  0, 0, 0, 0, 0, mk(0,0,0,0,0,3));     // entry 1 squashed, $9 older survives
      // MemBusy freeze during pending forward from stage 2
      step(15, 0, 1,  0,  0, 0, 0,  8, 1, 0, 0, 0, z);                   // add $8
      step(16, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, z);                   // bubble
      step(17, 0, 1,  8,  0, 1, 0,  9, 1, 0, 0, 1, mk(1,1,0,0,2,0));
      step(18, 0, 1,  8,  0, 1, 0,  9, 1, 0, 1, 1, mk(1,1,0,0,2,0));     // branch ignored while busy
      step(19, 0, 1,  8,  0, 1, 0,  9, 1, 0, 0, 1, mk(1,1,0,0,2,0));
      step(20, 0, 1,  8,  0, 1, 0,  9, 1, 0, 0, 0, mk(0,0,0,0,2,0));     // resumes
      step(21, 0, 1,  8,  9, 1, 1,  0, 0, 0, 0, 0, mk(0,0,0,0,3,1));     // shifted after drop
      // reset during a load-use stall
      step(22, 0, 1,  0,  0, 0, 0, 14, 1, 1, 0, 0, z);                   // lw $14
      step(23, 1, 1, 14,  0, 1, 0, 15, 1, 0, 0, 0, mk(1,1,0,1,1,0));     // stall, reset asserted
      step(24, 0, 1, 14,  0, 1, 0, 15, 1, 0, 0, 0, z);                   // same inputs, cleared
      step(25, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, z);
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge CLOCK);
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain got %0d pending required 0 pending", exp_q.size());
      end
      @(posedge CLOCK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
